// File: rtl/ev3a_gen_sched.sv
`default_nettype none
// ============================================================================
// Module   : ev3a_gen_sched
// Purpose  : Generation scheduler for the EV3a evolutionary datapath. Counts
//            the initial population into RAM, then walks every child through
//            selection, optional crossover, mutation, evaluation and
//            replacement for NUM_GENERATIONS generations, finishing with a
//            one-cycle out_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ev3a_gen_sched #(
    parameter int          POP_SIZE        = 40,
    parameter int          NUM_GENERATIONS = 50,
    parameter logic [7:0]  CROSSFRACTION   = 8'd204,
    parameter int          IDX_W           = 6,
    parameter int          GEN_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_ind,
    input  logic [7:0]       rand8,
    input  logic             sel_done,
    input  logic             cross_done,
    input  logic             mut_done,
    input  logic             eval_done,
    input  logic             repl_done,
    output logic             load_we,
    output logic [IDX_W-1:0] load_addr,
    output logic             sel_start,
    output logic             cross_start,
    output logic             mut_start,
    output logic             eval_start,
    output logic             repl_start,
    output logic [IDX_W-1:0] ind_idx,
    output logic [GEN_W-1:0] gen_cnt,
    output logic             busy,
    output logic             out_valid
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(POP_SIZE - 1);
    localparam logic [GEN_W-1:0] C_GEN_END  = GEN_W'(NUM_GENERATIONS);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_SEL   = 4'd2,
        S_CROSS = 4'd3,
        S_MUT   = 4'd4,
        S_EVAL  = 4'd5,
        S_REPL  = 4'd6,
        S_NEXT  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] load_cnt_q;
    logic [IDX_W-1:0] ind_idx_q;
    logic [GEN_W-1:0] gen_cnt_q;
    logic             sel_start_q;
    logic             cross_start_q;
    logic             mut_start_q;
    logic             eval_start_q;
    logic             repl_start_q;
    logic             busy_q;
    logic             out_valid_q;
    logic [GEN_W-1:0] gen_inc_d;

    // The first strobe in IDLE is itself write 0, so the write enable is
    // live in IDLE as well as LOAD; the count sits at 0 outside LOAD.
    assign load_we   = in_valid_ind && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign load_addr = load_cnt_q;
    assign gen_inc_d = gen_cnt_q + GEN_W'(1);

    // Scheduler FSM: every start pulse defaults low and is raised only on
    // entry to its phase, so each is exactly one cycle wide. A done is
    // honoured only once the own start pulse has dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= '0;
            ind_idx_q     <= '0;
            gen_cnt_q     <= '0;
            sel_start_q   <= 1'b0;
            cross_start_q <= 1'b0;
            mut_start_q   <= 1'b0;
            eval_start_q  <= 1'b0;
            repl_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            sel_start_q   <= 1'b0;
            cross_start_q <= 1'b0;
            mut_start_q   <= 1'b0;
            eval_start_q  <= 1'b0;
            repl_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid_ind) begin
                        state_q    <= S_LOAD;
                        busy_q     <= 1'b1;
                        load_cnt_q <= IDX_W'(1);
                        ind_idx_q  <= '0;
                        gen_cnt_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid_ind) begin
                        if (load_cnt_q == C_LAST_IDX) begin
                            load_cnt_q  <= '0;
                            state_q     <= S_SEL;
                            sel_start_q <= 1'b1;
                        end else begin
                            load_cnt_q <= load_cnt_q + IDX_W'(1);
                        end
                    end
                end
                S_SEL: begin
                    if (!sel_start_q && sel_done) begin
                        if (rand8 < CROSSFRACTION) begin
                            state_q       <= S_CROSS;
                            cross_start_q <= 1'b1;
                        end else begin
                            state_q     <= S_MUT;
                            mut_start_q <= 1'b1;
                        end
                    end
                end
                S_CROSS: begin
                    if (!cross_start_q && cross_done) begin
                        state_q     <= S_MUT;
                        mut_start_q <= 1'b1;
                    end
                end
                S_MUT: begin
                    if (!mut_start_q && mut_done) begin
                        state_q      <= S_EVAL;
                        eval_start_q <= 1'b1;
                    end
                end
                S_EVAL: begin
                    if (!eval_start_q && eval_done) begin
                        state_q      <= S_REPL;
                        repl_start_q <= 1'b1;
                    end
                end
                S_REPL: begin
                    if (!repl_start_q && repl_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (ind_idx_q < C_LAST_IDX) begin
                        ind_idx_q   <= ind_idx_q + IDX_W'(1);
                        state_q     <= S_SEL;
                        sel_start_q <= 1'b1;
                    end else begin
                        ind_idx_q <= '0;
                        gen_cnt_q <= gen_inc_d;
                        if (gen_inc_d == C_GEN_END) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q     <= S_SEL;
                            sel_start_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sel_start   = sel_start_q;
    assign cross_start = cross_start_q;
    assign mut_start   = mut_start_q;
    assign eval_start  = eval_start_q;
    assign repl_start  = repl_start_q;
    assign ind_idx     = ind_idx_q;
    assign gen_cnt     = gen_cnt_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;

endmodule
`default_nettype wire
